// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access sizes, FSM states,
// byte-strobe masks and the alignment rule.
package lsu_pkg;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2,
        SIZE_D = 2'd3
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_e;

    localparam logic [7:0] STRB_B = 8'h01;
    localparam logic [7:0] STRB_H = 8'h03;
    localparam logic [7:0] STRB_W = 8'h0F;
    localparam logic [7:0] STRB_D = 8'hFF;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SIZE_B:  return STRB_B;
            SIZE_H:  return STRB_H;
            SIZE_W:  return STRB_W;
            default: return STRB_D;
        endcase
    endfunction

    // An access is aligned when its byte offset is a multiple of its size.
    function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
        case (size)
            SIZE_H:  return ~off[0];
            SIZE_W:  return off[1:0] == 2'b00;
            SIZE_D:  return off == 3'b000;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load path: moves the addressed lane down to bit 0, then
// truncates to the access size and sign- or zero-extends.
module lsu_load_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [2:0]      offset,
    input  logic [1:0]      size,
    input  logic            is_unsigned,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;
    logic            sign;

    always_comb begin
        shifted = rdata >> {offset, 3'b000};
        data    = shifted;
        sign    = 1'b0;
        case (size)
            SIZE_B: begin
                sign = ~is_unsigned & shifted[7];
                data = {{(XLEN-8){sign}}, shifted[7:0]};
            end
            SIZE_H: begin
                sign = ~is_unsigned & shifted[15];
                data = {{(XLEN-16){sign}}, shifted[15:0]};
            end
            SIZE_W: begin
                sign = ~is_unsigned & shifted[31];
                data = {{(XLEN-32){sign}}, shifted[31:0]};
            end
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit for the MEM stage: captures one aligned request, runs a
// valid/ready request to data memory, waits for the response and reports completion.
module lsu
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic            flush,
    output logic            stall,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            misalign,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    output logic [7:0]      dmem_wstrb,
    input  logic            dmem_resp_valid,
    input  logic [XLEN-1:0] dmem_rdata
);

    state_e          state_reg, state_next;
    logic            flushed_reg, flushed_next;
    logic [XLEN-1:0] addr_reg;
    logic [XLEN-1:0] wdata_reg;
    logic [1:0]      size_reg;
    logic            unsigned_reg;
    logic            we_reg;
    logic            resp_valid_reg;
    logic [XLEN-1:0] resp_rdata_reg;
    logic            misalign_reg;

    logic            req_aligned;
    logic            in_idle;
    logic            accept;
    logic            reject;
    logic            resp_take;
    logic [XLEN-1:0] load_data;

    assign req_aligned = is_aligned(req_size, req_addr[2:0]);
    assign in_idle     = (state_reg == ST_IDLE);
    // The completion cycle still shows the finished op on req_valid; do not re-issue it.
    assign accept      = in_idle && req_valid && req_aligned && !flush && !resp_valid_reg;
    assign reject      = in_idle && req_valid && !req_aligned && !flush;
    assign resp_take   = (state_reg == ST_WAIT) && dmem_resp_valid;

    always_comb begin
        state_next     = state_reg;
        flushed_next   = flushed_reg;
        stall          = 1'b0;
        dmem_req_valid = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                stall = req_valid && req_aligned && !resp_valid_reg;
                if (accept) begin
                    state_next   = ST_REQ;
                    flushed_next = 1'b0;
                end
            end
            ST_REQ: begin
                stall          = 1'b1;
                dmem_req_valid = 1'b1;
                // A flush coinciding with the handshake is too late to abort; it only hides the result.
                if (dmem_req_ready) begin
                    state_next   = ST_WAIT;
                    flushed_next = flushed_reg | flush;
                end else if (flush) begin
                    state_next = ST_IDLE;
                end
            end
            ST_WAIT: begin
                stall        = 1'b1;
                flushed_next = flushed_reg | flush;
                if (dmem_resp_valid) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (!sys_rst) begin
            stall          = 1'b0;
            dmem_req_valid = 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_reg      <= ST_IDLE;
            flushed_reg    <= 1'b0;
            addr_reg       <= '0;
            wdata_reg      <= '0;
            size_reg       <= '0;
            unsigned_reg   <= 1'b0;
            we_reg         <= 1'b0;
            resp_valid_reg <= 1'b0;
            resp_rdata_reg <= '0;
            misalign_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            flushed_reg    <= flushed_next;
            misalign_reg   <= reject;
            resp_valid_reg <= resp_take && !flushed_next;
            if (accept) begin
                addr_reg     <= req_addr;
                wdata_reg    <= req_wdata;
                size_reg     <= req_size;
                unsigned_reg <= req_unsigned;
                we_reg       <= req_we;
            end
            if (resp_take) begin
                resp_rdata_reg <= load_data;
            end
        end
    end

    lsu_load_align #(.XLEN(XLEN)) u_load_align (
        .rdata       (dmem_rdata),
        .offset      (addr_reg[2:0]),
        .size        (size_reg),
        .is_unsigned (unsigned_reg),
        .data        (load_data)
    );

    assign dmem_we    = we_reg;
    assign dmem_addr  = {addr_reg[XLEN-1:3], 3'b000};
    assign dmem_wdata = wdata_reg << {addr_reg[2:0], 3'b000};
    assign dmem_wstrb = size_mask(size_reg) << addr_reg[2:0];
    assign resp_valid = resp_valid_reg;
    assign resp_rdata = resp_rdata_reg;
    assign misalign   = misalign_reg;

endmodule
